// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Holds default dimensions, the hardwired zero register index and a constant clog2.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations set a bit, writebacks clear it.
// A reservation in the same cycle as a write to that register wins (newer producer).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2,
    parameter int AW    = clog2_f(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rsv_en,
    input  logic [AW-1:0]         i_rsv_addr,
    input  logic [NREGS-1:0]      i_clr,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    output logic [NREAD-1:0]      o_rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        set_mask = '0;
        if (i_rsv_en && i_rsv_addr != AW'(ZERO_REG))
            set_mask[i_rsv_addr] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            busy <= '0;
        else
            busy <= (busy & ~i_clr) | set_mask;
    end

    always_comb begin
        o_rd_busy = '0;
        for (int p = 0; p < NREAD; p++)
            o_rd_busy[p] = busy[i_rd_addr[p*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered reads, r0 hardwired to zero and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy-clear to reads; otherwise read-before-write.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    localparam int AW    = clog2_f(NREGS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREAD-1:0]        i_rd_en,
    input  logic [NREAD*AW-1:0]     i_rd_addr,
    output logic [NREAD*XLEN-1:0]   o_rd_data,
    output logic [NREAD-1:0]        o_rd_valid,
    output logic [NREAD-1:0]        o_rd_busy,
    input  logic [NWRITE-1:0]       i_wr_en,
    input  logic [NWRITE*AW-1:0]    i_wr_addr,
    input  logic [NWRITE*XLEN-1:0]  i_wr_data,
    input  logic                    i_rsv_en,
    input  logic [AW-1:0]           i_rsv_addr
);

    logic [XLEN-1:0]  regs   [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREAD-1:0] sb_busy;
    logic [XLEN-1:0]  rd_data_d [NREAD];
    logic [NREAD-1:0] rd_busy_d;

    // Later ports overwrite earlier ones, so the highest-index writer wins a collision.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++)
            wr_val[r] = '0;
        for (int w = 0; w < NWRITE; w++) begin
            if (i_wr_en[w] && i_wr_addr[w*AW +: AW] != AW'(ZERO_REG)) begin
                wr_hit[i_wr_addr[w*AW +: AW]] = 1'b1;
                wr_val[i_wr_addr[w*AW +: AW]] = i_wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // NOTE: the array is reset because registers must read 0 after reset; this rules out RAM macros.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .i_clr      (wr_hit),
        .i_rd_addr  (i_rd_addr),
        .o_rd_busy  (sb_busy)
    );

    // r0 needs no special case: it is never written nor reserved, so it reads 0 / not busy.
    always_comb begin
        rd_busy_d = '0;
        for (int p = 0; p < NREAD; p++) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit[i_rd_addr[p*AW +: AW]]) begin
                rd_data_d[p] = wr_val[i_rd_addr[p*AW +: AW]];
                rd_busy_d[p] = 1'b0;
            end else begin
                rd_data_d[p] = regs[i_rd_addr[p*AW +: AW]];
                rd_busy_d[p] = sb_busy[p];
            end
`else
            rd_data_d[p] = regs[i_rd_addr[p*AW +: AW]];
            rd_busy_d[p] = sb_busy[p];
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= '0;
            o_rd_busy  <= '0;
        end else begin
            o_rd_valid <= i_rd_en;
            for (int p = 0; p < NREAD; p++) begin
                if (i_rd_en[p]) begin
                    o_rd_data[p*XLEN +: XLEN] <= rd_data_d[p];
                    o_rd_busy[p]              <= rd_busy_d[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed cases plus random traffic against an array-based model.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    i_clk;
    logic                    i_rst_n;
    logic [NREAD-1:0]        i_rd_en;
    logic [NREAD*AW-1:0]     i_rd_addr;
    logic [NREAD*XLEN-1:0]   o_rd_data;
    logic [NREAD-1:0]        o_rd_valid;
    logic [NREAD-1:0]        o_rd_busy;
    logic [NWRITE-1:0]       i_wr_en;
    logic [NWRITE*AW-1:0]    i_wr_addr;
    logic [NWRITE*XLEN-1:0]  i_wr_data;
    logic                    i_rsv_en;
    logic [AW-1:0]           i_rsv_addr;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_rd_busy  (o_rd_busy),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    logic [XLEN-1:0] exp_data  [NREAD];
    bit              exp_valid [NREAD];
    bit              exp_busy  [NREAD];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        for (int p = 0; p < NREAD; p++) begin
            exp_data[p]  = '0;
            exp_valid[p] = 1'b0;
            exp_busy[p]  = 1'b0;
        end
    endtask

    // Applies the architectural rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        bit              hit [NREGS];
        logic [XLEN-1:0] val [NREGS];
        int a;
        for (int r = 0; r < NREGS; r++) begin
            hit[r] = 1'b0;
            val[r] = '0;
        end
        for (int w = 0; w < NWRITE; w++) begin
            if (i_wr_en[w]) begin
                a = int'(i_wr_addr[w*AW +: AW]);
                if (a != 0) begin
                    hit[a] = 1'b1;
                    val[a] = i_wr_data[w*XLEN +: XLEN];
                end
            end
        end
        for (int p = 0; p < NREAD; p++) begin
            exp_valid[p] = i_rd_en[p];
            if (i_rd_en[p]) begin
                a = int'(i_rd_addr[p*AW +: AW]);
                if (a == 0) begin
                    exp_data[p] = '0;
                    exp_busy[p] = 1'b0;
                end else if (BYP && hit[a]) begin
                    exp_data[p] = val[a];
                    exp_busy[p] = 1'b0;
                end else begin
                    exp_data[p] = m_regs[a];
                    exp_busy[p] = m_busy[a];
                end
            end
        end
        for (int r = 0; r < NREGS; r++) begin
            if (hit[r]) begin
                m_regs[r] = val[r];
                m_busy[r] = 1'b0;
            end
        end
        if (i_rsv_en && i_rsv_addr != '0)
            m_busy[int'(i_rsv_addr)] = 1'b1;
    endtask

    always @(negedge i_clk) begin
        if (cmp_on) begin
            for (int p = 0; p < NREAD; p++) begin
                check($sformatf("rd_valid[%0d]", p), 64'(o_rd_valid[p]), 64'(exp_valid[p]));
                check($sformatf("rd_data[%0d]", p), 64'(o_rd_data[p*XLEN +: XLEN]), 64'(exp_data[p]));
                check($sformatf("rd_busy[%0d]", p), 64'(o_rd_busy[p]), 64'(exp_busy[p]));
            end
        end
    end

    task automatic idle();
        i_rd_en   = '0;
        i_wr_en   = '0;
        i_rsv_en  = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        i_rd_en[p] = 1'b1;
        i_rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
        i_wr_en[w] = 1'b1;
        i_wr_addr[w*AW +: AW] = AW'(a);
        i_wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_rsv(input int a);
        i_rsv_en   = 1'b1;
        i_rsv_addr = AW'(a);
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic cycle();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0)
            return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    initial begin
        i_rst_n    = 1'b0;
        i_rd_addr  = '0;
        i_wr_addr  = '0;
        i_wr_data  = '0;
        i_rsv_addr = '0;
        idle();
        model_reset();
        repeat (3) @(negedge i_clk);
        cmp_on = 1'b1;
        check("reset_valid", 64'(o_rd_valid), 64'd0);
        check("reset_data", 64'(o_rd_data), 64'd0);
        check("reset_busy", 64'(o_rd_busy), 64'd0);
        i_rst_n = 1'b1;

        // All registers read zero and not busy out of reset.
        for (int a = 1; a < NREGS; a++) begin
            idle();
            set_rd(0, a);
            cycle();
            check($sformatf("reset_r%0d_data", a), 64'(o_rd_data[XLEN-1:0]), 64'd0);
            check($sformatf("reset_r%0d_busy", a), 64'(o_rd_busy[0]), 64'd0);
        end

        idle(); set_wr(0, 5, 32'hDEADBEEF); cycle();
        idle(); set_rd(1, 5); cycle();
        check("r5_data_p1", 64'(o_rd_data[XLEN +: XLEN]), 64'hDEADBEEF);
        check("r5_valid_p1", 64'(o_rd_valid[1]), 64'd1);
        idle(); cycle();
        check("valid_drop_p1", 64'(o_rd_valid[1]), 64'd0);
        check("data_hold_p1", 64'(o_rd_data[XLEN +: XLEN]), 64'hDEADBEEF);

        idle(); set_wr(0, 0, 32'h1234); set_rsv(0); cycle();
        idle(); set_rd(0, 0); cycle();
        check("r0_data", 64'(o_rd_data[XLEN-1:0]), 64'd0);
        check("r0_busy", 64'(o_rd_busy[0]), 64'd0);

        idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); cycle();
        idle(); set_rd(0, 7); cycle();
        check("r7_collision", 64'(o_rd_data[XLEN-1:0]), 64'h22);

        idle(); set_wr(0, 9, 32'h55); cycle();
        idle(); set_wr(1, 9, 32'hAA); set_rd(0, 9); cycle();
        check("r9_same_cycle", 64'(o_rd_data[XLEN-1:0]), BYP ? 64'hAA : 64'h55);
        idle(); set_rd(0, 9); cycle();
        check("r9_reread", 64'(o_rd_data[XLEN-1:0]), 64'hAA);

        idle(); set_rsv(3); cycle();
        idle(); set_rd(0, 3); cycle();
        check("r3_reserved", 64'(o_rd_busy[0]), 64'd1);
        idle(); set_wr(0, 3, 32'h33); set_rsv(3); cycle();
        idle(); set_rd(0, 3); cycle();
        check("r3_wr_rsv_busy", 64'(o_rd_busy[0]), 64'd1);
        check("r3_wr_rsv_data", 64'(o_rd_data[XLEN-1:0]), 64'h33);
        idle(); set_wr(1, 3, 32'h44); cycle();
        idle(); set_rd(0, 3); cycle();
        check("r3_cleared", 64'(o_rd_busy[0]), 64'd0);

        // Random traffic, addresses biased low to provoke collisions and hazards.
        for (int n = 0; n < 1500; n++) begin
            i_rd_en = NREAD'($urandom);
            for (int p = 0; p < NREAD; p++)
                i_rd_addr[p*AW +: AW] = rand_addr();
            i_wr_en = NWRITE'($urandom);
            for (int w = 0; w < NWRITE; w++) begin
                i_wr_addr[w*AW +: AW]   = rand_addr();
                i_wr_data[w*XLEN +: XLEN] = XLEN'($urandom);
            end
            i_rsv_en   = ($urandom_range(0, 3) == 0);
            i_rsv_addr = rand_addr();
            cycle();
        end

        // Reset with reads in flight: they must be discarded.
        idle(); set_rd(0, 5); set_rd(1, 9);
        #1 i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        check("midrst_valid", 64'(o_rd_valid), 64'd0);
        check("midrst_data", 64'(o_rd_data), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle();
        check("postrst_valid", 64'(o_rd_valid), 64'd3);
        check("postrst_data", 64'(o_rd_data), 64'd0);
        idle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
